pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 redirect_valid  input  1  SHALL mean the branch unit requests a PC change.
REQ-005 br_data_ok  input  1  SHALL qualify redirect_valid; a redirect is taken only when both are high on a posedge.
REQ-006 redirect_pc  input  64  SHALL carry the redirect target.
REQ-007 ireq_valid  output  1  SHALL mean an instruction fetch request is presented.
REQ-008 ireq_addr  output  64  SHALL carry the fetch address.
REQ-009 ireq_ready  input  1  SHALL mean the memory accepts the request this cycle.
REQ-010 iresp_valid  input  1  SHALL mean iresp_data is valid this cycle.
REQ-011 iresp_data  input  32  SHALL carry the fetched instruction.
REQ-012 inst_valid  output  1  SHALL mean inst and inst_pc are valid for decode.
REQ-013 inst_pc  output  64  SHALL carry the PC of inst.
REQ-014 inst  output  32  SHALL carry the instruction word.
REQ-015 inst_ready  input  1  SHALL mean decode consumes inst this cycle.
REQ-016 misalign  output  1  SHALL flag a misaligned redirect target (MISALIGN_CHECK_EN only; tied 0 otherwise).

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, HOLD; IDLE -> REQ unconditionally one cycle after reset release.
REQ-018 In REQ, ireq_valid SHALL be 1; on ireq_valid && ireq_ready the FSM SHALL go to WAIT.
REQ-019 ireq_addr SHALL remain stable while ireq_valid is high and ireq_ready is low.
REQ-020 In WAIT, on iresp_valid with no stale flag, inst/inst_pc SHALL be registered and inst_valid SHALL be 1 the next cycle (1-cycle latency), state -> HOLD.
REQ-021 In HOLD, on inst_ready the FSM SHALL go to REQ with ireq_addr = inst_pc + 4 (64-bit wrap) and inst_valid SHALL drop the next cycle.
REQ-022 A taken redirect SHALL set the next fetch PC to redirect_pc and override the sequential PC + 4.
REQ-023 Redirect in REQ before acceptance: ireq_addr SHALL NOT change; when the request is accepted, the stale flag SHALL be set; after the stale response is dropped, the next request SHALL use redirect_pc.
REQ-024 Redirect in WAIT, including the same cycle as iresp_valid: that response SHALL be dropped (inst_valid stays 0), then REQ at redirect_pc.
REQ-025 Redirect in HOLD, including with inst_ready high: inst_valid SHALL be 0 the next cycle, state -> REQ at redirect_pc.
REQ-026 A second redirect before the first is issued SHALL replace the pending target (last wins).
REQ-027 iresp_valid outside WAIT SHALL be ignored.

Reset
REQ-028 On rst_n low, regardless of state: state = IDLE, ireq_valid = 0, ireq_addr = RESET_PC, inst_valid = 0, inst_pc = 0, inst = 0, misalign = 0, stale flag and pending redirect cleared.
REQ-029 Reset asserted mid-transaction SHALL discard any outstanding request and response.

Configuration
REQ-030 With MISALIGN_CHECK_EN defined, a taken redirect with redirect_pc[1:0] != 0 SHALL set misalign = 1 (sticky until reset), and ireq_valid SHALL be held 0.
REQ-031 Without MISALIGN_CHECK_EN, redirect_pc SHALL be used with bits [1:0] forced to 0, and misalign SHALL be constant 0.

Verification
REQ-032 Reset release, ireq_ready = 1, 1-cycle memory -> requests at 8000_0000, 8000_0004, 8000_0008 in order; each inst_valid carries the matching inst_pc.
REQ-033 ireq_ready held 0 for 5 cycles -> ireq_valid = 1 and ireq_addr constant; single request issued once ready = 1.
REQ-034 Redirect to 8000_0100 in the same cycle as iresp_valid in WAIT -> no inst_valid for that response; next ireq_addr = 8000_0100.
REQ-035 Redirect to 8000_0200 during HOLD with inst_ready = 0 -> inst_valid = 0 the next cycle; next ireq_addr = 8000_0200.
REQ-036 Redirects to 8000_0300 then 8000_0400 while in REQ unaccepted -> stale response dropped; next request = 8000_0400.
REQ-037 With MISALIGN_CHECK_EN, redirect to 8000_0102 -> misalign = 1, ireq_valid = 0 until rst_n pulses low; without the macro, fetch continues at 8000_0100.

Source files
------------

// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-side bundle for pc_redirect_ctrl: branch redirect, imem request/response, decode handoff.
// master = the PC controller, slave = branch unit / imem / decode environment.
interface pc_redirect_ctrl_if;
  logic        redirect_valid;
  logic        br_data_ok;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        inst_valid;
  logic [63:0] inst_pc;
  logic [31:0] inst;
  logic        inst_ready;
  logic        misalign;

  modport master (
    input  redirect_valid,
    input  br_data_ok,
    input  redirect_pc,
    input  ireq_ready,
    input  iresp_valid,
    input  iresp_data,
    input  inst_ready,
    output ireq_valid,
    output ireq_addr,
    output inst_valid,
    output inst_pc,
    output inst,
    output misalign
  );

  modport slave (
    output redirect_valid,
    output br_data_ok,
    output redirect_pc,
    output ireq_ready,
    output iresp_valid,
    output iresp_data,
    output inst_ready,
    input  ireq_valid,
    input  ireq_addr,
    input  inst_valid,
    input  inst_pc,
    input  inst,
    input  misalign
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC/fetch controller: one outstanding imem fetch, 1-entry decode hold, branch redirects.
// Ports: clk, rst_n (async low), bus (pc_redirect_ctrl_if.master). Option: MISALIGN_CHECK_EN.
module pc_redirect_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input logic             clk,
  input logic             rst_n,
  pc_redirect_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic [63:0] ipc_q;
  logic [63:0] ipc_d;
  logic [31:0] inst_q;
  logic [31:0] inst_d;
  logic        iv_q;
  logic        iv_d;
  logic        stale_q;
  logic        stale_d;
  logic        pend_q;
  logic        pend_d;
  logic [63:0] tgt_q;
  logic [63:0] tgt_d;
  logic        take;
  logic [63:0] tgt;
  logic        blocked;
  logic        req_v;

  assign take = bus.redirect_valid && bus.br_data_ok;

`ifdef MISALIGN_CHECK_EN
  logic mis_q;

  assign tgt = bus.redirect_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else if (take && (bus.redirect_pc[1:0] != 2'b00)) begin
      mis_q <= 1'b1;
    end
  end

  assign blocked = mis_q;
`else
  assign tgt     = bus.redirect_pc & ~64'h3;
  assign blocked = 1'b0;
`endif

  assign req_v         = (state == REQ) && !blocked;
  assign bus.ireq_valid = req_v;
  assign bus.ireq_addr  = pc_q;
  assign bus.inst_valid = iv_q;
  assign bus.inst_pc    = ipc_q;
  assign bus.inst       = inst_q;
  assign bus.misalign   = blocked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      ipc_q   <= 64'd0;
      inst_q  <= 32'd0;
      iv_q    <= 1'b0;
      stale_q <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= 64'd0;
    end else begin
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      inst_q  <= inst_d;
      iv_q    <= iv_d;
      stale_q <= stale_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_d      = pc_q;
    ipc_d     = ipc_q;
    inst_d    = inst_q;
    iv_d      = iv_q;
    stale_d   = stale_q;
    pend_d    = pend_q;
    tgt_d     = tgt_q;
    unique case (state)
      IDLE: begin
        state_nxt = REQ;
        if (take) pc_d = tgt;
      end
      REQ: begin
        // The presented address must not move; park the target.
        if (take) begin
          pend_d = 1'b1;
          tgt_d  = tgt;
        end
        if (req_v && bus.ireq_ready) begin
          state_nxt = WAIT;
          stale_d   = pend_q || take;
        end
      end
      WAIT: begin
        if (take) begin
          pend_d = 1'b1;
          tgt_d  = tgt;
        end
        if (bus.iresp_valid) begin
          if (stale_q || take) begin
            state_nxt = REQ;
            pc_d      = take ? tgt : tgt_q;
            stale_d   = 1'b0;
            pend_d    = 1'b0;
          end else begin
            state_nxt = HOLD;
            ipc_d     = pc_q;
            inst_d    = bus.iresp_data;
            iv_d      = 1'b1;
          end
        end else if (take) begin
          stale_d = 1'b1;
        end
      end
      HOLD: begin
        if (take) begin
          state_nxt = REQ;
          iv_d      = 1'b0;
          pc_d      = tgt;
        end else if (bus.inst_ready) begin
          state_nxt = REQ;
          iv_d      = 1'b0;
          pc_d      = ipc_q + 64'd4;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: transaction-level model + directed redirect scenarios.
// Optional MISALIGN_CHECK_EN build is covered by the same bench.
module tb_pc_redirect_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   mem_delay;

  pc_redirect_ctrl_if bus ();

  pc_redirect_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  // Instruction memory: answers each accepted request after mem_delay cycles.
  initial begin
    logic        acc;
    logic [63:0] a;
    logic [63:0] maddr;
    int          cnt;
    bus.iresp_valid = 1'b0;
    bus.iresp_data  = 32'd0;
    cnt   = 0;
    maddr = 64'd0;
    forever begin
      @(negedge clk);
      acc = rst_n && bus.ireq_valid && bus.ireq_ready;
      a   = bus.ireq_addr;
      @(posedge clk);
      #1;
      bus.iresp_valid = 1'b0;
      if (!rst_n) begin
        cnt = 0;
      end else begin
        if (acc) begin
          cnt   = mem_delay;
          maddr = a;
        end
        if (cnt == 1) begin
          bus.iresp_valid = 1'b1;
          bus.iresp_data  = memf(maddr);
          cnt = 0;
        end else if (cnt > 1) begin
          cnt--;
        end
      end
    end
  end

  // Transaction model: what is requested, what is in flight, what decode holds.
  logic        m_idle;
  logic        m_open;
  logic [63:0] m_req_addr;
  logic        m_req_dirty;
  logic        m_out;
  logic [63:0] m_out_addr;
  logic        m_out_dirty;
  logic        m_hold;
  logic [63:0] m_hold_pc;
  logic [63:0] m_next;
  logic        m_mis;
  logic [63:0] acc_log[$];
  logic [63:0] dlv_log[$];

  always @(negedge clk) begin : model
    logic        exp_req;
    logic        t;
    logic [63:0] tg;
    if (!rst_n) begin
      m_idle  = 1'b1;
      m_open  = 1'b0;
      m_out   = 1'b0;
      m_hold  = 1'b0;
      m_next  = RST_PC;
      m_mis   = 1'b0;
    end else begin
      exp_req = !m_idle && !m_out && !m_hold && !m_mis;
      check("ireq_valid", bus.ireq_valid, exp_req);
      check("inst_valid", bus.inst_valid, m_hold);
      check("misalign", bus.misalign, m_mis);
      if (m_hold) begin
        check("inst_pc", bus.inst_pc, m_hold_pc);
        check("inst", bus.inst, memf(m_hold_pc));
      end
      if (exp_req && bus.ireq_valid) begin
        if (m_open) begin
          check("ireq_addr_stable", bus.ireq_addr, m_req_addr);
        end else begin
          check("ireq_addr", bus.ireq_addr, m_next);
          m_open      = 1'b1;
          m_req_addr  = m_next;
          m_req_dirty = 1'b0;
        end
      end
      t = bus.redirect_valid && bus.br_data_ok;
`ifdef MISALIGN_CHECK_EN
      tg = bus.redirect_pc;
`else
      tg = {bus.redirect_pc[63:2], 2'b00};
`endif
      if (m_idle) begin
        m_idle = 1'b0;
      end else if (m_open && !m_mis && bus.ireq_ready) begin
        m_open      = 1'b0;
        m_out       = 1'b1;
        m_out_addr  = m_req_addr;
        m_out_dirty = m_req_dirty || t;
        acc_log.push_back(m_req_addr);
      end else if (m_open && t) begin
        m_req_dirty = 1'b1;
      end else if (m_out) begin
        if (bus.iresp_valid) begin
          m_out = 1'b0;
          if (!(m_out_dirty || t)) begin
            m_hold    = 1'b1;
            m_hold_pc = m_out_addr;
            dlv_log.push_back(m_out_addr);
          end
        end else if (t) begin
          m_out_dirty = 1'b1;
        end
      end else if (m_hold) begin
        if (t) begin
          m_hold = 1'b0;
        end else if (bus.inst_ready) begin
          m_hold = 1'b0;
          m_next = m_hold_pc + 64'd4;
        end
      end
      if (t) begin
        m_next = tg;
`ifdef MISALIGN_CHECK_EN
        if (tg[1:0] != 2'b00) m_mis = 1'b1;
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.br_data_ok     = 1'b1;
    bus.redirect_pc    = pc;
    cyc(1);
    bus.redirect_valid = 1'b0;
    bus.br_data_ok     = 1'b0;
  endtask

  // which: 0 = accept, 1 = request presented, 2 = inst_valid.
  task automatic wait_for(input int which, input string tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      case (which)
        0:       hit = bus.ireq_valid && bus.ireq_ready;
        1:       hit = bus.ireq_valid;
        default: hit = bus.inst_valid;
      endcase
    end
    check(tag, hit, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] a;
    int          n0;
    int          d0;
    vectors     = 0;
    miscompares = 0;
    mem_delay   = 1;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.br_data_ok     = 1'b0;
    bus.redirect_pc    = 64'd0;
    bus.ireq_ready     = 1'b1;
    bus.inst_ready     = 1'b1;
    cyc(3);
    #3;
    check("rst ireq_valid", bus.ireq_valid, 1'b0);
    check("rst ireq_addr", bus.ireq_addr, 64'h8000_0000);
    check("rst inst_valid", bus.inst_valid, 1'b0);
    check("rst inst_pc", bus.inst_pc, 64'd0);
    check("rst inst", bus.inst, 32'd0);
    check("rst misalign", bus.misalign, 1'b0);
    cyc(1);
    rst_n = 1'b1;

    // Sequential fetch from reset.
    for (int k = 0; k < 60 && dlv_log.size() < 3; k++) cyc(1);
    check("seq dlv count", 64'(dlv_log.size() >= 3), 64'd1);
    check("seq acc0", acc_log[0], 64'h8000_0000);
    check("seq acc1", acc_log[1], 64'h8000_0004);
    check("seq acc2", acc_log[2], 64'h8000_0008);
    check("seq dlv0", dlv_log[0], 64'h8000_0000);
    check("seq dlv2", dlv_log[2], 64'h8000_0008);

    // Back-pressure: address held while not ready, issued once.
    bus.ireq_ready = 1'b0;
    wait_for(1, "bp req");
    a = bus.ireq_addr;
    for (int k = 0; k < 5; k++) begin
      #3;
      check("bp valid", bus.ireq_valid, 1'b1);
      check("bp addr", bus.ireq_addr, a);
      cyc(1);
    end
    n0 = acc_log.size();
    bus.ireq_ready = 1'b1;
    wait_for(0, "bp accept");
    check("bp single", 64'(acc_log.size()), 64'(n0 + 1));
    check("bp acc addr", acc_log[$], a);

    // Redirect in WAIT coinciding with the response.
    wait_for(0, "wait accept");
    d0 = dlv_log.size();
    redirect(64'h8000_0100);
    #3;
    check("wait drop iv", bus.inst_valid, 1'b0);
    wait_for(0, "wait redir accept");
    check("wait redir addr", acc_log[$], 64'h8000_0100);
    check("wait no dlv", 64'(dlv_log.size()), 64'(d0));

    // Redirect in HOLD without decode consuming.
    bus.inst_ready = 1'b0;
    wait_for(2, "hold inst");
    redirect(64'h8000_0200);
    #3;
    check("hold drop iv", bus.inst_valid, 1'b0);
    bus.inst_ready = 1'b1;
    wait_for(0, "hold redir accept");
    check("hold redir addr", acc_log[$], 64'h8000_0200);

    // Two redirects while a request is unaccepted; last one wins.
    bus.ireq_ready = 1'b0;
    wait_for(1, "req req");
    a = bus.ireq_addr;
    redirect(64'h8000_0300);
    redirect(64'h8000_0400);
    #3;
    check("req addr held", bus.ireq_addr, a);
    d0 = dlv_log.size();
    bus.ireq_ready = 1'b1;
    wait_for(0, "req stale accept");
    check("req stale addr", acc_log[$], a);
    wait_for(0, "req redir accept");
    check("req redir addr", acc_log[$], 64'h8000_0400);
    check("req stale dropped", 64'(dlv_log.size()), 64'(d0));

    // Misaligned redirect target.
    bus.inst_ready = 1'b0;
    wait_for(2, "mis inst");
    redirect(64'h8000_0102);
    bus.inst_ready = 1'b1;
`ifdef MISALIGN_CHECK_EN
    cyc(4);
    #3;
    check("mis flag", bus.misalign, 1'b1);
    check("mis blocked", bus.ireq_valid, 1'b0);
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    #3;
    check("mis cleared", bus.misalign, 1'b0);
`else
    wait_for(0, "mis accept");
    check("mis addr", acc_log[$], 64'h8000_0100);
    check("mis flag", bus.misalign, 1'b0);
`endif

    // Asynchronous reset in the middle of an outstanding fetch.
    mem_delay = 3;
    wait_for(0, "rst accept");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst ireq_valid", bus.ireq_valid, 1'b0);
    check("arst ireq_addr", bus.ireq_addr, 64'h8000_0000);
    check("arst inst_valid", bus.inst_valid, 1'b0);
    cyc(2);
    mem_delay = 1;
    n0 = acc_log.size();
    rst_n = 1'b1;
    wait_for(0, "arst accept");
    check("arst first addr", acc_log[n0], 64'h8000_0000);

    // PC + 4 wraps at 64 bits.
    bus.inst_ready = 1'b0;
    wait_for(2, "wrap inst");
    redirect(64'hffff_ffff_ffff_fffc);
    bus.inst_ready = 1'b1;
    wait_for(0, "wrap accept0");
    check("wrap addr0", acc_log[$], 64'hffff_ffff_ffff_fffc);
    wait_for(0, "wrap accept1");
    check("wrap addr1", acc_log[$], 64'd0);
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
